regfile_mp_sb: RTL and testbench

//  Parametrised multi-port register file for the dual-issue ID stage, with a per-register busy scoreboard.
//  NRD combinational read ports with WB write-through bypass; NWR write ports with fixed priority.
//  The scoreboard marks destinations busy at issue and clears them at writeback, so the issue logic can stall.

---
 rtl/regfile_mp_sb.sv | 129 ++++++++++++
 tb/tb_regfile_mp_sb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file for a dual-issue decode stage.
// Combinational read ports with write-through bypass, fixed-priority write
// ports (index 0 wins), a per-register busy scoreboard and a registered
// debug read port. Register 0 is hardwired to zero.
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 4,
  parameter int NWR    = 2,
  parameter int NISS   = 2
) (
  input  logic                   clk,
  input  logic                   btnc_i,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*ADDR_W-1:0]  wr_addr,
  input  logic [NWR*DATA_W-1:0]  wr_data,
  input  logic [NISS-1:0]        iss_en,
  input  logic [NISS*ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0]      dbg_addr,
  output logic [DATA_W-1:0]      dbg_data,
  output logic [NREG-1:0]        busy_vec
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [DATA_W-1:0] r_dbg;

  logic [NREG-1:0]   w_busy_nxt;
  logic [NREG-1:0]   w_clr;
  logic [NREG-1:0]   w_set;
  logic [ADDR_W-1:0] w_ra [NRD];
  logic [DATA_W-1:0] w_rd_data [NRD];
  logic [NRD-1:0]    w_rd_hit;
  logic [NRD-1:0]    w_rd_busy;
  logic              w_match;

  // An address names a real, writable register: non-zero and inside the array.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != {ADDR_W{1'b0}}) && (32'(a) < 32'(NREG));
  endfunction

  // Register array update; ports are applied high index first so port 0 lands last and wins.
  always_ff @(posedge clk) begin
    if (!btnc_i) begin
      for (int r = 0; r < NREG; r++) begin
        r_regs[r] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int j = NWR - 1; j >= 0; j--) begin
        if (wr_en[j] && addr_ok(wr_addr[j*ADDR_W +: ADDR_W])) begin
          r_regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read ports: committed value, overridden by the highest-priority matching write.
  always_comb begin
    w_rd_hit  = {NRD{1'b0}};
    w_rd_busy = {NRD{1'b0}};
    w_match   = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      w_ra[k]      = rd_addr[k*ADDR_W +: ADDR_W];
      w_rd_data[k] = addr_ok(w_ra[k]) ? r_regs[w_ra[k]] : {DATA_W{1'b0}};
      // Scan low priority first so the lowest-index match is the final override.
      for (int j = NWR - 1; j >= 0; j--) begin
        w_match      = wr_en[j] && addr_ok(w_ra[k]) &&
                       (wr_addr[j*ADDR_W +: ADDR_W] == w_ra[k]);
        w_rd_data[k] = w_match ? wr_data[j*DATA_W +: DATA_W] : w_rd_data[k];
        w_rd_hit[k]  = w_rd_hit[k] | w_match;
      end
      // A value supplied by write-through is not a hazard for the reader.
      w_rd_busy[k] = (addr_ok(w_ra[k]) ? r_busy[w_ra[k]] : 1'b0) & ~w_rd_hit[k];
    end
  end

  // Scoreboard next state: writeback clears, issue sets, set beats clear, r0 never busy.
  always_comb begin
    w_clr      = {NREG{1'b0}};
    w_set      = {NREG{1'b0}};
    w_busy_nxt = {NREG{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      for (int j = 0; j < NWR; j++) begin
        w_clr[r] = w_clr[r] |
                   (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r)));
      end
      for (int i = 0; i < NISS; i++) begin
        w_set[r] = w_set[r] |
                   (iss_en[i] && (iss_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r)));
      end
      w_busy_nxt[r] = (r != 0) && ((r_busy[r] & ~w_clr[r]) | w_set[r]);
    end
  end

  // Scoreboard register; reset flushes all outstanding producers.
  always_ff @(posedge clk) begin
    if (!btnc_i) begin
      r_busy <= {NREG{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Debug read of committed state only, one cycle of latency.
  always_ff @(posedge clk) begin
    if (!btnc_i) begin
      r_dbg <= {DATA_W{1'b0}};
    end else begin
      r_dbg <= addr_ok(dbg_addr) ? r_regs[dbg_addr] : {DATA_W{1'b0}};
    end
  end

  // Flatten read results onto the output buses.
  always_comb begin
    rd_data = {(NRD*DATA_W){1'b0}};
    for (int k = 0; k < NRD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = w_rd_data[k];
    end
  end

  assign rd_busy  = w_rd_busy;
  assign dbg_data = r_dbg;
  assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: scoreboard-driven bench for regfile_mp_sb.
// Directed scenarios first, then a randomised phase checked against a
// small behavioural model. The DUT is built with NREG=24 so that
// out-of-range addresses (24..31) are reachable.
module tb_regfile_mp_sb;
  localparam int DW   = 32;
  localparam int NR   = 24;
  localparam int AW   = 5;
  localparam int NRD  = 4;
  localparam int NWR  = 2;
  localparam int NISS = 2;

  logic                 clk = 1'b0;
  logic                 btnc_i;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*DW-1:0]    rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*DW-1:0]    wr_data;
  logic [NISS-1:0]      iss_en;
  logic [NISS*AW-1:0]   iss_addr;
  logic [AW-1:0]        dbg_addr;
  logic [DW-1:0]        dbg_data;
  logic [NR-1:0]        busy_vec;

  regfile_mp_sb #(.DATA_W(DW), .NREG(NR), .ADDR_W(AW), .NRD(NRD), .NWR(NWR), .NISS(NISS)) dut (
    .clk(clk), .btnc_i(btnc_i), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] q_exp [$];
  string       q_tag [$];

  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [63:0] v);
    q_tag.push_back(tag);
    q_exp.push_back(v);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    string t;
    logic [63:0] e;
    if (q_exp.size() == 0) begin
      check_val("sb_empty", obs, 64'hDEAD_BEEF_0BAD_F00D);
    end else begin
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      check_val(t, obs, e);
    end
  endtask

  function automatic logic [DW-1:0] rdd(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  task automatic idle();
    wr_en  = '0;
    iss_en = '0;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[j]              = 1'b1;
    wr_addr[j*AW +: AW]   = a;
    wr_data[j*DW +: DW]   = d;
  endtask

  task automatic set_iss(input int i, input logic [AW-1:0] a);
    iss_en[i]             = 1'b1;
    iss_addr[i*AW +: AW]  = a;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Model: rd value and bypass hit for address a; lowest-index write matches first.
  task automatic m_read(input int a, output logic [DW-1:0] d, output logic hit);
    hit = 1'b0;
    d   = '0;
    if (a != 0 && a < NR) begin
      d = m_regs[a];
      for (int j = 0; j < NWR; j++) begin
        if (!hit && wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
          d   = wr_data[j*DW +: DW];
          hit = 1'b1;
        end
      end
    end
  endtask

  // Model: apply one clock edge with the currently driven inputs.
  task automatic m_edge();
    logic [NR-1:0] nb;
    logic clr, set;
    for (int r = 0; r < NR; r++) begin
      clr = 1'b0;
      set = 1'b0;
      for (int j = 0; j < NWR; j++) clr |= wr_en[j] && int'(wr_addr[j*AW +: AW]) == r;
      for (int i = 0; i < NISS; i++) set |= iss_en[i] && int'(iss_addr[i*AW +: AW]) == r;
      nb[r] = (r != 0) && ((m_busy[r] && !clr) || set);
    end
    for (int j = NWR - 1; j >= 0; j--) begin
      if (wr_en[j] && wr_addr[j*AW +: AW] != 0 && int'(wr_addr[j*AW +: AW]) < NR)
        m_regs[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
    end
    m_busy = nb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ed, exp_dbg;
    logic          eh;
    btnc_i = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = '0; iss_addr = '0; dbg_addr = '0;

    // 1 reset with writes and issues requested
    set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd3); set_rd(3, 5'd0);
    set_wr(0, 5'd1, 32'h1111); set_wr(1, 5'd2, 32'h2222);
    set_iss(0, 5'd3); set_iss(1, 5'd4); dbg_addr = 5'd1;
    repeat (3) tick();
    btnc_i = 1'b1; idle();
    push_exp("rst_busy_vec", 64'd0); push_exp("rst_dbg", 64'd0);
    for (int k = 0; k < NRD; k++) push_exp("rst_rd", 64'd0);
    push_exp("rst_rd_busy", 64'd0);
    settle();
    pop_chk(busy_vec); pop_chk(dbg_data);
    for (int k = 0; k < NRD; k++) pop_chk(rdd(k));
    pop_chk(rd_busy);
    tick();
    push_exp("rst_dbg_after", 64'd0); settle(); pop_chk(dbg_data);

    // 2 dual write collision on r5
    set_wr(0, 5'd5, 32'hAAAA); set_wr(1, 5'd5, 32'h5555); set_rd(0, 5'd5);
    push_exp("coll_bypass", 64'hAAAA); push_exp("coll_busy", 64'd0);
    settle(); pop_chk(rdd(0)); pop_chk(rd_busy[0]);
    tick(); idle(); dbg_addr = 5'd5;
    push_exp("coll_commit", 64'hAAAA); settle(); pop_chk(rdd(0));
    tick();
    push_exp("coll_dbg", 64'hAAAA); settle(); pop_chk(dbg_data);
    set_wr(1, 5'd7, 32'h77); tick(); idle();

    // 3 bypass mix
    set_wr(0, 5'd3, 32'h11); set_wr(1, 5'd4, 32'h22);
    set_rd(0, 5'd3); set_rd(1, 5'd4); set_rd(2, 5'd0); set_rd(3, 5'd7);
    push_exp("mix_r3", 64'h11); push_exp("mix_r4", 64'h22);
    push_exp("mix_r0", 64'h0);  push_exp("mix_r7", 64'h77); push_exp("mix_busy", 64'd0);
    settle();
    for (int k = 0; k < NRD; k++) pop_chk(rdd(k));
    pop_chk(rd_busy);
    tick(); idle();

    // 4 write and issue to r0
    set_wr(0, 5'd0, 32'hFFFF); set_iss(0, 5'd0); set_rd(0, 5'd0);
    push_exp("r0_bypass", 64'd0); push_exp("r0_busy", 64'd0);
    settle(); pop_chk(rdd(0)); pop_chk(rd_busy[0]);
    tick(); idle();
    push_exp("r0_commit", 64'd0); push_exp("r0_busy_vec", 64'd0);
    settle(); pop_chk(rdd(0)); pop_chk(busy_vec);

    // 5 scoreboard set then writeback clear on r8
    set_iss(0, 5'd8); set_rd(0, 5'd8);
    push_exp("sb_pre", 64'd0); settle(); pop_chk(busy_vec);
    tick(); idle();
    push_exp("sb_set_vec", 64'h100); push_exp("sb_set_rdb", 64'b0001);
    settle(); pop_chk(busy_vec); pop_chk(rd_busy);
    set_wr(1, 5'd8, 32'h88);
    push_exp("sb_wb_data", 64'h88); push_exp("sb_wb_rdb", 64'd0); push_exp("sb_wb_vec", 64'h100);
    settle(); pop_chk(rdd(0)); pop_chk(rd_busy); pop_chk(busy_vec);
    tick(); idle();
    push_exp("sb_clr_vec", 64'd0); push_exp("sb_clr_data", 64'h88);
    settle(); pop_chk(busy_vec); pop_chk(rdd(0));

    // 6 set/clear race on r9
    set_iss(1, 5'd9); set_wr(0, 5'd9, 32'h99); set_rd(1, 5'd9);
    push_exp("race_bypass", 64'h99); push_exp("race_rdb", 64'd0);
    settle(); pop_chk(rdd(1)); pop_chk(rd_busy);
    tick(); idle();
    push_exp("race_vec", 64'h200); push_exp("race_data", 64'h99); push_exp("race_rdb2", 64'b0010);
    settle(); pop_chk(busy_vec); pop_chk(rdd(1)); pop_chk(rd_busy);

    // out-of-range r30 dropped, top register r23 written
    set_wr(0, 5'd30, 32'h1234); set_iss(0, 5'd30); set_wr(1, 5'd23, 32'hCAFE);
    set_rd(2, 5'd30); set_rd(3, 5'd23);
    push_exp("oor_rd", 64'd0); push_exp("top_bypass", 64'hCAFE); push_exp("oor_rdb", 64'b0010);
    settle(); pop_chk(rdd(2)); pop_chk(rdd(3)); pop_chk(rd_busy);
    tick(); idle(); dbg_addr = 5'd30;
    push_exp("oor_commit", 64'd0); push_exp("top_commit", 64'hCAFE); push_exp("oor_vec", 64'h200);
    settle(); pop_chk(rdd(2)); pop_chk(rdd(3)); pop_chk(busy_vec);
    tick();
    push_exp("oor_dbg", 64'd0); settle(); pop_chk(dbg_data);

    // mid-operation reset discards in-flight write and issue
    set_iss(0, 5'd10); set_wr(0, 5'd11, 32'hBB); btnc_i = 1'b0;
    tick(); btnc_i = 1'b1; idle();
    set_rd(0, 5'd9); set_rd(1, 5'd10); set_rd(2, 5'd11); set_rd(3, 5'd23);
    push_exp("mrst_vec", 64'd0);
    for (int k = 0; k < NRD; k++) push_exp("mrst_rd", 64'd0);
    settle(); pop_chk(busy_vec);
    for (int k = 0; k < NRD; k++) pop_chk(rdd(k));

    // randomised phase against the model, starting from the reset state
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_busy  = '0;
    exp_dbg = '0;
    for (int c = 0; c < 60; c++) begin
      for (int j = 0; j < NWR; j++) begin
        wr_en[j] = 1'($urandom_range(0, 1));
        wr_addr[j*AW +: AW] = AW'($urandom_range(0, 27));
        wr_data[j*DW +: DW] = $urandom;
      end
      for (int i = 0; i < NISS; i++) begin
        iss_en[i] = 1'($urandom_range(0, 1));
        iss_addr[i*AW +: AW] = AW'($urandom_range(0, 27));
      end
      for (int k = 0; k < NRD; k++) set_rd(k, AW'($urandom_range(0, 27)));
      for (int k = 0; k < NRD; k++) begin
        m_read(int'(rd_addr[k*AW +: AW]), ed, eh);
        push_exp("rnd_rd", 64'(ed));
        push_exp("rnd_rdb", 64'(eh ? 1'b0 : ((rd_addr[k*AW +: AW] != 0 && int'(rd_addr[k*AW +: AW]) < NR)
                                           ? m_busy[rd_addr[k*AW +: AW]] : 1'b0)));
      end
      push_exp("rnd_vec", 64'(m_busy));
      if (c > 0) push_exp("rnd_dbg", 64'(exp_dbg));
      settle();
      for (int k = 0; k < NRD; k++) begin
        pop_chk(rdd(k));
        pop_chk(rd_busy[k]);
      end
      pop_chk(busy_vec);
      if (c > 0) pop_chk(dbg_data);
      dbg_addr = AW'($urandom_range(0, 27));
      exp_dbg  = (dbg_addr != 0 && int'(dbg_addr) < NR) ? m_regs[dbg_addr] : '0;
      m_edge();
      tick();
    end

    check_val("sb_drain", 64'(q_exp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
